// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: bundles the two requester ports and the BRAM-side bus of
// bram_arbiter. The slave modport is the arbiter's view; the master modport is
// the environment's view (requesters plus the BRAM itself).
interface bram_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_W = DATA_WIDTH / 8;

    // Port A (CPU pipeline)
    logic                  a_valid;
    logic                  a_ready;
    logic                  a_write;
    logic [MASK_W-1:0]     a_wmask;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_rvalid;

    // Port B (secondary master, e.g. debug/DMA loader)
    logic                  b_valid;
    logic                  b_ready;
    logic                  b_write;
    logic [MASK_W-1:0]     b_wmask;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_rvalid;

    // Single-port BRAM, read data registered (valid the cycle after the address)
    logic                  mem_write;
    logic [MASK_W-1:0]     mem_wmask;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  a_valid, a_write, a_wmask, a_addr, a_wdata,
        output a_ready, a_rdata, a_rvalid,
        input  b_valid, b_write, b_wmask, b_addr, b_wdata,
        output b_ready, b_rdata, b_rvalid,
        output mem_write, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_valid, a_write, a_wmask, a_addr, a_wdata,
        input  a_ready, a_rdata, a_rvalid,
        output b_valid, b_write, b_wmask, b_addr, b_wdata,
        input  b_ready, b_rdata, b_rvalid,
        input  mem_write, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM (1-cycle read latency, byte write
// mask) between port A (priority) and port B. One access per cycle total, no
// buffering; read data is steered back to the port that issued the read.
//
// Optional build macro BRAM_ARB_RR_EN: when defined, arbitration is
// round-robin on a last-grant bit and the anti-starvation counter (MAX_WAIT)
// is not built. When undefined, A has fixed priority and B is force-granted
// after MAX_WAIT consecutive denials.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic           clk,
    input  logic           rstn,
    bram_arbiter_if.slave  bus
);
    localparam int MASK_W = DATA_WIDTH / 8;

    logic grant_a;
    logic grant_b;

    // read-return flags: one cycle after a granted read on that port
    logic rd_a_q, rd_a_d;
    logic rd_b_q, rd_b_d;

    logic                  mem_write_d;
    logic [MASK_W-1:0]     mem_wmask_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

`ifdef BRAM_ARB_RR_EN
    // 1 = B was granted most recently; resets to B so A wins the first conflict
    logic last_b_q, last_b_d;

    // Round-robin grant: on conflict the port not granted last wins.
    // Grants are held off while reset is asserted.
    always_comb begin
        grant_b = rstn && bus.b_valid && (!bus.a_valid || !last_b_q);
        grant_a = rstn && bus.a_valid && !grant_b;
    end

    // Last-grant bit follows every grant, holds across idle cycles
    always_comb begin
        last_b_d = last_b_q;
        if (grant_b)
            last_b_d = 1'b1;
        else if (grant_a)
            last_b_d = 1'b0;
    end

    // Last-grant register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_b_q <= 1'b1;
        else
            last_b_q <= last_b_d;
    end
`else
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // consecutive cycles B has been requesting without a grant
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Fixed priority to A; B wins when A is idle or B has waited MAX_WAIT.
    // Grants are held off while reset is asserted.
    always_comb begin
        grant_b = rstn && bus.b_valid && (!bus.a_valid || wait_cnt_q == MAX_WAIT_C);
        grant_a = rstn && bus.a_valid && !grant_b;
    end

    // Starvation counter: counts denied B cycles, saturates at MAX_WAIT,
    // clears once B is served or drops its request
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.b_valid || grant_b)
            wait_cnt_d = '0;
        else if (wait_cnt_q != MAX_WAIT_C)
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_d;
    end
`endif

    // Memory-side mux: granted port drives the BRAM; idle leaves A's address
    // and data on the bus with the strobe and byte enables low
    always_comb begin
        mem_write_d = 1'b0;
        mem_wmask_d = '0;
        mem_addr_d  = bus.a_addr;
        mem_wdata_d = bus.a_wdata;
        if (grant_b) begin
            mem_write_d = bus.b_write;
            mem_wmask_d = bus.b_wmask;
            mem_addr_d  = bus.b_addr;
            mem_wdata_d = bus.b_wdata;
        end else if (grant_a) begin
            mem_write_d = bus.a_write;
            mem_wmask_d = bus.a_wmask;
            mem_addr_d  = bus.a_addr;
            mem_wdata_d = bus.a_wdata;
        end
    end

    // Drive the BRAM bus and the combinational ready handshakes
    always_comb begin
        bus.mem_write = mem_write_d;
        bus.mem_wmask = mem_wmask_d;
        bus.mem_addr  = mem_addr_d;
        bus.mem_wdata = mem_wdata_d;
        bus.a_ready   = grant_a;
        bus.b_ready   = grant_b;
    end

    // Remember which port owns the read data coming back next cycle
    always_comb begin
        rd_a_d = grant_a && !bus.a_write;
        rd_b_d = grant_b && !bus.b_write;
    end

    // Read-return flags; async clear drops any read in flight at reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_a_q <= 1'b0;
            rd_b_q <= 1'b0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    // Steer BRAM read data to its owner; the other port sees zero
    always_comb begin
        bus.a_rvalid = rd_a_q;
        bus.b_rvalid = rd_b_q;
        bus.a_rdata  = rd_a_q ? bus.mem_rdata : '0;
        bus.b_rdata  = rd_b_q ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: table-driven check of bram_arbiter against a behavioural
// BRAM. Read returns are scoreboarded per port: expected data is queued at the
// grant and popped the following cycle when rvalid must appear.
module tb_bram_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Behavioural single-port BRAM, read-first, registered read data.
    // Preset contents are (re)loaded while reset is held.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!rstn) begin
            bram[14'h3f80] <= 32'h0000_0013;
            bram[14'h0010] <= 32'h1122_3344;
            bram[14'h0020] <= 32'hA0A0_A0A0;
            bram[14'h0030] <= 32'hB0B0_B0B0;
            bram[14'h0001] <= 32'h1111_0001;
            bram[14'h0002] <= 32'h2222_0002;
            bram[14'h0003] <= 32'h3333_0003;
            bram[14'h0050] <= 32'h5555_5555;
            bram[14'h0060] <= 32'h6666_6666;
        end else if (bus.mem_write) begin
            for (int i = 0; i < MW; i++)
                if (bus.mem_wmask[i]) bram[bus.mem_addr][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
        end
        bus.mem_rdata <= bram[bus.mem_addr];
    end

    typedef struct {
        logic          av, aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic [MW-1:0] am;
        logic          bv, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic [MW-1:0] bm;
        logic          ea, eb;   // expected a_ready / b_ready
        logic [DW-1:0] er;       // expected read data if this row grants a read
    } vec_t;

    vec_t          vt[$];
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic av, aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad, input logic [MW-1:0] am,
        input logic bv, bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd, input logic [MW-1:0] bm,
        input logic ea, eb, input logic [DW-1:0] er);
        vec_t v;
        v.av = av; v.aw = aw; v.aa = aa; v.ad = ad; v.am = am;
        v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd; v.bm = bm;
        v.ea = ea; v.eb = eb; v.er = er;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, 0, '0);
    endfunction

    task automatic drive(input vec_t v);
        bus.a_valid = v.av; bus.a_write = v.aw; bus.a_addr = v.aa; bus.a_wdata = v.ad; bus.a_wmask = v.am;
        bus.b_valid = v.bv; bus.b_write = v.bw; bus.b_addr = v.ba; bus.b_wdata = v.bd; bus.b_wmask = v.bm;
    endtask

    // Every read granted last cycle must return now, on its own port only
    task automatic check_returns();
        logic          ea, eb;
        logic [DW-1:0] da, db;
        ea = (qa.size() != 0);
        eb = (qb.size() != 0);
        da = ea ? qa.pop_front() : '0;
        db = eb ? qb.pop_front() : '0;
        chk("a_rvalid", 32'(bus.a_rvalid), 32'(ea));
        chk("a_rdata",  bus.a_rdata, da);
        chk("b_rvalid", 32'(bus.b_rvalid), 32'(eb));
        chk("b_rdata",  bus.b_rdata, db);
    endtask

    // Grant and BRAM-bus checks for one row, then scoreboard any granted read
    task automatic check_row(input vec_t v, input int i);
        string sfx;
        sfx = $sformatf("[%0d]", i);
        chk({"a_ready", sfx}, 32'(bus.a_ready), 32'(v.ea));
        chk({"b_ready", sfx}, 32'(bus.b_ready), 32'(v.eb));
        chk({"mem_write", sfx}, 32'(bus.mem_write), 32'(v.eb ? v.bw : (v.ea ? v.aw : 1'b0)));
        chk({"mem_wmask", sfx}, 32'(bus.mem_wmask), 32'(v.eb ? v.bm : (v.ea ? v.am : 4'h0)));
        chk({"mem_addr", sfx}, 32'(bus.mem_addr), 32'(v.eb ? v.ba : v.aa));
        if (v.ea || v.eb)
            chk({"mem_wdata", sfx}, bus.mem_wdata, v.eb ? v.bd : v.ad);
        if (bus.a_valid && bus.a_ready && !bus.a_write) qa.push_back(v.er);
        if (bus.b_valid && bus.b_ready && !bus.b_write) qb.push_back(v.er);
    endtask

    initial begin
        logic eb_k;
        // ---- stimulus table ----
        vt.push_back(mk(1, 0, 14'h3f80, '0, 4'h0,  0, 0, '0, '0, '0,  1, 0, 32'h0000_0013)); // 0
        vt.push_back(idle());                                                                  // 1
        vt.push_back(mk(1, 1, 14'h0010, 32'hAABB_CCDD, 4'b0101, 0, 0, '0, '0, '0, 1, 0, '0));  // 2
        vt.push_back(mk(0, 0, '0, '0, '0, 1, 0, 14'h0010, '0, 4'h0, 0, 1, 32'h11BB_33DD));    // 3
        vt.push_back(idle());                                                                  // 4
        // 5..14: both ports hammer reads
        for (int k = 0; k < 10; k++) begin
`ifdef BRAM_ARB_RR_EN
            eb_k = (k % 2 == 1);
`else
            eb_k = (k % 5 == 4);
`endif
            vt.push_back(mk(1, 0, 14'h0020, '0, 4'h0, 1, 0, 14'h0030, '0, 4'h0, !eb_k, eb_k,
                            eb_k ? 32'hB0B0_B0B0 : 32'hA0A0_A0A0));
        end
        vt.push_back(idle());                                                                  // 15
        vt.push_back(mk(1, 0, 14'h0001, '0, '0, 0, 0, '0, '0, '0, 1, 0, 32'h1111_0001));      // 16
        vt.push_back(mk(0, 0, '0, '0, '0, 1, 0, 14'h0002, '0, '0, 0, 1, 32'h2222_0002));      // 17
        vt.push_back(mk(1, 0, 14'h0003, '0, '0, 0, 0, '0, '0, '0, 1, 0, 32'h3333_0003));      // 18
        vt.push_back(idle());                                                                  // 19
        vt.push_back(idle());                                                                  // 20
        vt.push_back(mk(1, 1, 14'h0040, 32'hCAFE_F00D, 4'hF, 0, 0, '0, '0, '0, 1, 0, '0));    // 21
        vt.push_back(mk(0, 0, '0, '0, '0, 1, 0, 14'h0040, '0, '0, 0, 1, 32'hCAFE_F00D));      // 22
        vt.push_back(mk(1, 1, 14'h0050, 32'h1234_5678, 4'b1000, 1, 0, 14'h0050, '0, '0, 1, 0, '0)); // 23
        vt.push_back(mk(0, 0, '0, '0, '0, 1, 0, 14'h0050, '0, '0, 0, 1, 32'h1255_5555));      // 24
        vt.push_back(mk(0, 0, '0, '0, '0, 1, 1, 14'h0060, 32'hDEAD_BEEF, 4'b0011, 0, 1, '0)); // 25
        vt.push_back(mk(1, 0, 14'h0060, '0, '0, 0, 0, '0, '0, '0, 1, 0, 32'h6666_BEEF));      // 26
        vt.push_back(idle());                                                                  // 27

        // ---- reset state: requests present but nothing may reach the BRAM ----
        drive(mk(1, 1, 14'h0005, 32'hFFFF_FFFF, 4'hF, 1, 1, 14'h0006, 32'hFFFF_FFFF, 4'hF, 0, 0, '0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(bus.a_ready), 0);
        chk("rst_b_ready", 32'(bus.b_ready), 0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 0);
        check_returns();
        drive(idle());
        rstn = 1'b1;

        // ---- table ----
        @(posedge clk); #1;
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            @(negedge clk);
            check_returns();
            check_row(vt[i], i);
            @(posedge clk); #1;
        end

        // ---- reset arriving one cycle after an A read grant ----
        drive(mk(1, 0, 14'h3f80, '0, '0, 0, 0, '0, '0, '0, 1, 0, '0));
        @(negedge clk);
        chk("pre_rst_a_ready", 32'(bus.a_ready), 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        drive(mk(1, 1, 14'h0007, 32'h0, 4'hF, 1, 0, 14'h0008, '0, '0, 0, 0, '0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_inflight_a_rvalid", 32'(bus.a_rvalid), 0);
            chk("rst_inflight_a_rdata", bus.a_rdata, 0);
            chk("rst_inflight_a_ready", 32'(bus.a_ready), 0);
            chk("rst_inflight_b_ready", 32'(bus.b_ready), 0);
            chk("rst_inflight_mem_write", 32'(bus.mem_write), 0);
            chk("rst_inflight_mem_wmask", 32'(bus.mem_wmask), 0);
        end
        drive(idle());
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_returns();
        // after release, a lone B request is granted immediately
        drive(mk(0, 0, '0, '0, '0, 1, 0, 14'h0002, '0, '0, 0, 1, 32'h2222_0002));
        #1;
        check_row(mk(0, 0, '0, '0, '0, 1, 0, 14'h0002, '0, '0, 0, 1, 32'h2222_0002), 100);
        @(posedge clk); #1;
        drive(idle());
        @(negedge clk);
        check_returns();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency BRAM (byte-lane write mask) between two requesters.
  - Port A: CPU pipeline.
  - Port B: secondary master, e.g. a debug/DMA loader.
- Fixed priority to A, with an anti-starvation counter that forces a B grant after MAX_WAIT consecutive denials.
- Sits between the requesters and the BRAM; routes read data back to the port that issued the read.

Parameters:
- ADDR_WIDTH, 14, word-address width (64 KiB at 32-bit words).
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- MAX_WAIT, 4, consecutive cycles B may be denied while requesting before a forced grant; range 1..255.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- a_valid  in  1  port A request.
- a_ready  out  1  port A granted this cycle (combinational).
- a_write  in  1  port A write, else read.
- a_wmask  in  DATA_WIDTH/8  port A byte enables.
- a_addr  in  ADDR_WIDTH  port A word address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_rvalid  out  1  port A read data valid.
- b_valid, b_ready, b_write, b_wmask, b_addr, b_wdata, b_rdata, b_rvalid: same as port A, for port B.
- mem_write  out  1  BRAM write strobe.
- mem_wmask  out  DATA_WIDTH/8  BRAM byte enables.
- mem_addr  out  ADDR_WIDTH  BRAM word address.
- mem_wdata  out  DATA_WIDTH  BRAM write data.
- mem_rdata  in  DATA_WIDTH  BRAM read data, registered, valid the cycle after the address.

Behaviour:
- Transfer: a request completes in the cycle where valid && ready. A requester holds its request signals stable until ready is seen.
- Grant decision, combinational from current inputs plus registered state:
  - grant_b = b_valid && (!a_valid || wait_cnt == MAX_WAIT).
  - grant_a = a_valid && !grant_b.
  - At most one grant per cycle.
- Memory side:
  - mem_addr, mem_wdata and mem_wmask come from the granted port.
  - mem_write = granted port's write bit.
  - Idle cycle: mem_write=0, mem_wmask=0, mem_addr=a_addr, mem_wdata=a_wdata.
- wait_cnt (8 bits, registered):
  - Increments when b_valid && !grant_b, saturating at MAX_WAIT.
  - Clears on grant_b or !b_valid.
- Read return:
  - Registered rd_a / rd_b flags are set for one cycle after a granted read (write=0) on that port.
  - a_rvalid = rd_a; b_rvalid = rd_b. One-cycle pulse, exactly one cycle after the grant.
  - a_rdata = mem_rdata when rd_a, else 0; same for B.
  - Back-to-back reads on alternating ports each return in order, one per cycle.
- Writes: no rvalid. A write granted in cycle N is visible to a read granted in cycle N+1.
- Simultaneous same-address write (A) and read (B): serialised by the grant; the later grant observes the earlier one.
- Reset (async assert, sync release):
  - wait_cnt=0, rd_a=rd_b=0, so a_rvalid=b_rvalid=0 and rdata=0.
  - While rstn=0: a_ready=b_ready=0, mem_write=0, mem_wmask=0.
  - A read granted in the cycle reset asserts never produces rvalid.
- No internal buffering: throughput is one access per cycle total.

Optional Feature:
- Macro: BRAM_ARB_RR_EN.
- Defined:
  - Arbitration becomes round-robin using a registered last-grant bit, reset value = B, so A wins the first conflict.
  - On conflict the port not last granted wins; last-grant updates on every grant.
  - wait_cnt and MAX_WAIT are unused and tied off.
- Undefined: fixed A priority with anti-starvation, as above.

Test Plan:
- Reset, then A read addr 0x3f80 with BRAM holding 0x00000013 at that address → a_ready=1 same cycle, a_rvalid=1 next cycle, a_rdata=0x00000013, b_rvalid=0.
- A write addr 0x0010, wdata 0xAABBCCDD, wmask 4'b0101, over old 0x11223344; then B read 0x0010 → b_rdata=0x11BB33DD one cycle after B's grant.
- A valid continuously and B valid from cycle 0, MAX_WAIT=4 → B denied cycles 0-3, granted cycle 4, A stalled in cycle 4 only; pattern repeats if B stays valid.
- Alternating reads A@1, B@2, A@3 in consecutive cycles → rvalid pulses one per cycle in the same order, each port getting only its own data and the other port's rdata=0.
- Assert rstn=0 one cycle after an A read grant → a_rvalid stays 0, mem_write=0 and both ready signals=0 until release.
- With BRAM_ARB_RR_EN: A and B both valid for 6 cycles → grants A,B,A,B,A,B.
